// File: rtl/edit_mem_buf_refcnt_if.sv
// Edit-memory buffer refcount op/release bus.
// master drives alloc/dec ops, slave returns ready and release.
interface edit_mem_buf_refcnt_if #(
  parameter int BPTR_NBITS = 4,
  parameter int CNT_NBITS  = 4
);
  logic                  alloc_valid;
  logic [BPTR_NBITS-1:0] alloc_ptr;
  logic [CNT_NBITS-1:0]  alloc_cnt;
  logic                  dec_valid;
  logic [BPTR_NBITS-1:0] dec_ptr;
  logic                  dec_ready;
  logic                  rel_buf_valid;
  logic [BPTR_NBITS-1:0] rel_buf_ptr;
  logic                  underflow_err;

  modport master (
    output alloc_valid, alloc_ptr, alloc_cnt,
    output dec_valid, dec_ptr,
    input  dec_ready,
    input  rel_buf_valid, rel_buf_ptr,
    input  underflow_err
  );

  modport slave (
    input  alloc_valid, alloc_ptr, alloc_cnt,
    input  dec_valid, dec_ptr,
    output dec_ready,
    output rel_buf_valid, rel_buf_ptr,
    output underflow_err
  );
endinterface

// File: rtl/edit_mem_buf_refcnt.sv
// Per-buffer reader refcount; pulses a release when a count hits zero.
// Two-stage pipe: S0 accepts and reads, S1 updates with write forwarding.
`ifndef EM_BUF_PTR_NBITS
`define EM_BUF_PTR_NBITS 4
`endif

module edit_mem_buf_refcnt #(
  parameter int BPTR_NBITS = `EM_BUF_PTR_NBITS,
  parameter int CNT_NBITS  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic freeb_init,
  output logic init_done,
  edit_mem_buf_refcnt_if.slave bus
);
  localparam int DEPTH = 1 << BPTR_NBITS;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } state_t;

  state_t                state;
  logic [BPTR_NBITS-1:0] clr_ptr;

  logic [CNT_NBITS-1:0]  mem [DEPTH];
  logic [CNT_NBITS-1:0]  rd_q;

  logic                  s1_valid;
  logic                  s1_alloc;
  logic [BPTR_NBITS-1:0] s1_ptr;
  logic [CNT_NBITS-1:0]  s1_cnt;

  logic                  lw_valid;
  logic [BPTR_NBITS-1:0] lw_ptr;
  logic [CNT_NBITS-1:0]  lw_data;

  logic                  op_live;
  logic                  acc_alloc;
  logic                  acc_dec;
  logic                  s1_act;
  logic [CNT_NBITS-1:0]  cur;
  logic                  we;
  logic [BPTR_NBITS-1:0] wa;
  logic [CNT_NBITS-1:0]  wd;
  logic                  rel_nx;
  logic                  und_nx;

  // a freeb_init cycle already kills S0 and S1 so nothing leaks out
  assign op_live   = init_done & ~freeb_init;
  assign acc_alloc = op_live & bus.alloc_valid;
  assign acc_dec   = op_live & bus.dec_valid & ~bus.alloc_valid;
  assign s1_act    = s1_valid & op_live;
  assign bus.dec_ready = init_done & ~bus.alloc_valid;

  // init FSM: clear whole table, then stay operational until reinit
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      clr_ptr   <= '0;
      init_done <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state     <= CLEAR;
          clr_ptr   <= '0;
          init_done <= 1'b0;
        end
        CLEAR: begin
          clr_ptr <= clr_ptr + BPTR_NBITS'(1);
          if (clr_ptr == '1) begin
            state     <= DONE;
            init_done <= 1'b1;
          end
        end
        DONE: begin
          if (freeb_init) begin
            state     <= IDLE;
            init_done <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          init_done <= 1'b0;
        end
      endcase
    end
  end

  // S1 update: pick forwarded or RAM count, decide write/release/underflow
  always_comb begin
    cur    = (lw_valid && lw_ptr == s1_ptr) ? lw_data : rd_q;
    we     = 1'b0;
    wa     = s1_ptr;
    wd     = '0;
    rel_nx = 1'b0;
    und_nx = 1'b0;
    unique case (1'b1)
      (state == CLEAR): begin
        we = 1'b1;
        wa = clr_ptr;
      end
      (state != CLEAR && s1_act && s1_alloc): begin
        we     = 1'b1;
        wd     = s1_cnt;
        rel_nx = (s1_cnt == '0);
      end
      (state != CLEAR && s1_act && !s1_alloc && cur == '0): begin
        und_nx = 1'b1;
      end
      (state != CLEAR && s1_act && !s1_alloc && cur != '0): begin
        we     = 1'b1;
        wd     = cur - CNT_NBITS'(1);
        rel_nx = (cur == CNT_NBITS'(1));
      end
      default: begin
      end
    endcase
  end

  // count RAM: sync read, old data on same-edge collision
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rd_q <= mem[bus.dec_ptr];
  end

  // pipeline, forwarding and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid          <= 1'b0;
      s1_alloc          <= 1'b0;
      s1_ptr            <= '0;
      s1_cnt            <= '0;
      lw_valid          <= 1'b0;
      lw_ptr            <= '0;
      lw_data           <= '0;
      bus.rel_buf_valid <= 1'b0;
      bus.rel_buf_ptr   <= '0;
      bus.underflow_err <= 1'b0;
    end else begin
      s1_valid          <= acc_alloc | acc_dec;
      s1_alloc          <= acc_alloc;
      s1_ptr            <= acc_alloc ? bus.alloc_ptr : bus.dec_ptr;
      s1_cnt            <= bus.alloc_cnt;
      lw_valid          <= we;
      lw_ptr            <= wa;
      lw_data           <= wd;
      bus.rel_buf_valid <= rel_nx;
      bus.underflow_err <= und_nx;
      if (rel_nx) bus.rel_buf_ptr <= s1_ptr;
    end
  end
endmodule

// File: doc/edit_mem_buf_refcnt.md
# edit_mem_buf_refcnt

Per-buffer reference counter for edit-memory buffers, sitting directly upstream of the free-buffer controller. When a buffer is allocated to a PU, this block records how many readers (unicast or multicast copies) will consume it. Each reader completion decrements the count. When the count reaches zero, the block emits a one-cycle `rel_buf_valid`/`rel_buf_ptr` pulse, which feeds the free-buffer controller's release input directly.

## Interface
- `BPTR_NBITS`, default `EM_BUF_PTR_NBITS`: buffer pointer width; the table holds 2^BPTR_NBITS entries.
- `CNT_NBITS`, default 4: reference count width.

- `clk`  in  1  clock.
- `` `RESET_SIG ``  in  1  reset; one clock, reset is synchronous and active-high.
- `freeb_init`  in  1  re-initialise the table; level, sampled in `DONE` only.
- `alloc_valid`  in  1  set a buffer's count; never backpressured.
- `alloc_ptr`  in  BPTR_NBITS  buffer being allocated.
- `alloc_cnt`  in  CNT_NBITS  initial reader count.
- `dec_valid`  in  1  one reader finished with a buffer.
- `dec_ptr`  in  BPTR_NBITS  buffer being decremented.
- `dec_ready`  out  1  dec accepted when `dec_valid & dec_ready`.
- `rel_buf_valid`  out  1  buffer count reached zero (pulse).
- `rel_buf_ptr`  out  BPTR_NBITS  released buffer.
- `underflow_err`  out  1  pulse: dec of a zero count.
- `init_done`  out  1  table cleared, block operational.

## Operation
- Storage: 2^BPTR_NBITS x CNT_NBITS RAM with 1 read port, 1 write port, synchronous read, and old-data-on-collision semantics.
- Init FSM states:
  - `IDLE`: always goes to `CLEAR` next cycle.
  - `CLEAR`: writes 0 to address `clr_ptr`, which increments from 0 each cycle. Goes to `DONE` after writing address all-ones.
  - `DONE`: goes to `IDLE` if `freeb_init`.
- `init_done` = registered (next state == `DONE`).
- Reset enters `IDLE`. A mid-operation reset or `freeb_init` discards all in-flight ops with no release pulses, then re-clears the whole table.
- Accept rules:
  - Only in `DONE`. `alloc_valid` outside `DONE` is ignored (illegal stimulus).
  - Alloc has priority: `dec_ready = init_done & ~alloc_valid`, combinational.
- Pipeline:
  - S0: accept one op; issue RAM read at `dec_ptr` for a dec.
  - S1: compute and write back; forward from the previous cycle's write when `s1_ptr == last_wr_ptr` and the last write was valid.
- Alloc at S1: write `alloc_cnt`. If `alloc_cnt == 0`, release immediately.
- Dec at S1, with `cur` = forwarded or RAM value:
  - `cur == 0`: no write, `underflow_err` pulse, no release.
  - `cur == 1`: write 0 and release.
  - Otherwise: write `cur-1`.
- Arithmetic: unsigned, modulo-free. Decrement never wraps, because zero is trapped as underflow.
- Back-to-back ops on the same ptr (alloc then dec, or dec then dec) must see each other's results via forwarding. There is no stall.

## Timing
- Reset values: `rel_buf_valid` 0, `rel_buf_ptr` 0, `underflow_err` 0, `init_done` 0, `dec_ready` 0.
- Init: `init_done` rises 2^BPTR_NBITS + 2 cycles after reset deassert.
- Latency: op accepted at cycle T gives `rel_buf_valid`/`underflow_err` registered at T+2, with `rel_buf_ptr` valid in the same cycle.
- Throughput: one op per cycle, so at most one release per cycle. This matches the free-buffer controller's single release port.
- `freeb_init` in `DONE`: `init_done` drops the next cycle, and `dec_ready` drops with it.

## Test plan
- **Init:** reset, BPTR_NBITS=4 → `init_done` = 0 for 17 cycles and 1 at cycle 18. All outputs hold their reset values throughout.
- **Unicast:** alloc ptr 5 with cnt 1, then dec ptr 5 three cycles later → exactly one `rel_buf_valid` with ptr 5, two cycles after the dec is accepted.
- **Multicast with forwarding:** alloc ptr 9 with cnt 3, then decs of ptr 9 on the three following consecutive cycles → no release after the first two decs; exactly one release of ptr 9 after the third. `underflow_err` never asserts.
- **Priority/backpressure:** `alloc_valid` and `dec_valid` high together for 4 cycles → `dec_ready` = 0 for all 4 cycles. The dec is accepted in the first cycle alloc drops, and no dec is lost.
- **Underflow and zero alloc:** dec of a never-allocated ptr 2 → `underflow_err` pulse, no release. Alloc ptr 3 with cnt 0 → release of ptr 3 at T+2.
- **Reinit mid-flight:** `freeb_init` asserted one cycle after a dec that would release → no release pulse; table re-cleared; `init_done` returns after 2^BPTR_NBITS + 2 cycles.
